// File: rtl/pwm_multi_pkg.sv
// Package for pwm_multi: shared types.
//   ramp_state_t  direction of the triangle counter (center-aligned build only)
package pwm_multi_pkg;

   typedef enum logic {
      ST_UP   = 1'b0,
      ST_DOWN = 1'b1
   } ramp_state_t;

endpackage

// File: rtl/pwm_multi_cnt.sv
// Shared period counter for pwm_multi.
// Build option: PWM_MULTI_CENTER_EN selects center-aligned (triangle) counting;
// otherwise the counter is edge-aligned and no down-count logic exists.
// Ports:
//   clk, rst     clock, async active-high reset
//   cnt          current count (registered)
//   boundary_c   high in the last cycle of a period (commit point)
//   sync_raw_c   high in the first cycle of a period
`include "pwm_multi_defs.vh"

module pwm_multi_cnt
   import pwm_multi_pkg::*;
#(
   parameter int unsigned period = 16,
   parameter int unsigned W      = `PWM_MULTI_W(period)
) (
   input  logic         clk,
   input  logic         rst,
   output logic [W-1:0] cnt,
   output logic         boundary_c,
   output logic         sync_raw_c
);

   localparam logic [W-1:0] CNT_MAX = W'(period - 32'd1);

   logic [W-1:0] cnt_q, cnt_d;

   assign cnt = cnt_q;

`ifdef PWM_MULTI_CENTER_EN
   ramp_state_t state_q, state_d;

   // Triangle: up to CNT_MAX, repeat it once while turning, down to 0,
   // repeat 0 once while turning; the down-ramp 0 closes the period.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      boundary_c = 1'b0;
      sync_raw_c = 1'b0;
      case (state_q)
         ST_UP: begin
            sync_raw_c = (cnt_q == '0);
            if (cnt_q == CNT_MAX) state_d = ST_DOWN;
            else                  cnt_d   = cnt_q + W'(1);
         end
         ST_DOWN: begin
            if (cnt_q == '0) begin
               boundary_c = 1'b1;
               state_d    = ST_UP;
            end else begin
               cnt_d = cnt_q - W'(1);
            end
         end
         default: state_d = ST_UP;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_UP;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
`else
   // Sawtooth: 0 .. CNT_MAX, then wrap.
   always_comb begin
      cnt_d      = cnt_q + W'(1);
      boundary_c = (cnt_q == CNT_MAX);
      sync_raw_c = (cnt_q == '0);
      if (boundary_c) cnt_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`endif

endmodule

// File: rtl/pwm_multi_defs.vh
// Shared helpers for pwm_multi: duty width and per-channel bus slice.
//   PWM_MULTI_W(p)             duty/counter width for a period of p states
//   PWM_MULTI_SLICE(bus, i, w) w-bit field of channel i in a packed bus
`ifndef PWM_MULTI_DEFS_VH
`define PWM_MULTI_DEFS_VH

`define PWM_MULTI_W(p) (((p) < 2) ? 1 : $clog2(p))
`define PWM_MULTI_SLICE(bus, i, w) bus[(i)*(w) +: (w)]

`endif

// File: rtl/pwm_multi.sv
// Multi-channel double-buffered PWM generator.
// Build option: PWM_MULTI_CENTER_EN selects center-aligned counting.
// Ports:
//   clk, rst   clock, async active-high reset
//   in         packed duty words, channel i at in[i*W +: W]
//   in_valid   in holds a new duty set
//   in_ready   shadow bank free (combinational from pending)
//   out        registered PWM outputs, one per channel
//   sync       registered one-cycle pulse with the first output of a period
`include "pwm_multi_defs.vh"

module pwm_multi
   import pwm_multi_pkg::*;
#(
   parameter  int unsigned period   = 16,
   parameter  int unsigned channels = 4,
   localparam int unsigned W        = `PWM_MULTI_W(period)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [channels*W-1:0] in,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [channels-1:0]   out,
   output logic                  sync
);

   logic [W-1:0] cnt;
   logic         boundary_c;
   logic         sync_raw_c;
   logic         xfer_c;
   logic         pending_q, pending_d;
   logic         sync_q, sync_d;

   pwm_multi_cnt #(
      .period (period),
      .W      (W)
   ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .cnt        (cnt),
      .boundary_c (boundary_c),
      .sync_raw_c (sync_raw_c)
   );

   assign in_ready = !pending_q;
   assign xfer_c   = in_valid && !pending_q;
   assign sync     = sync_q;

   // A boundary always empties the shadow bank (either committed or bypassed).
   always_comb begin
      pending_d = pending_q;
      sync_d    = sync_raw_c;
      if (boundary_c)  pending_d = 1'b0;
      else if (xfer_c) pending_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= 1'b0;
         sync_q    <= 1'b0;
      end else begin
         pending_q <= pending_d;
         sync_q    <= sync_d;
      end
   end

   for (genvar i = 0; i < int'(channels); i++) begin : g_ch
      logic [W-1:0] in_i;
      logic [W-1:0] shadow_q, shadow_d;
      logic [W-1:0] active_q, active_d;
      logic         out_q, out_d;

      assign in_i   = `PWM_MULTI_SLICE(in, i, W);
      assign out[i] = out_q;

      // Shadow captures on transfer; active only moves on the boundary,
      // taking the shadow if loaded, else a same-cycle transfer directly.
      always_comb begin
         shadow_d = shadow_q;
         active_d = active_q;
         out_d    = (active_q > cnt);
         if (xfer_c) shadow_d = in_i;
         if (boundary_c) begin
            if (pending_q)   active_d = shadow_q;
            else if (xfer_c) active_d = in_i;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
            out_q    <= 1'b0;
         end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            out_q    <= out_d;
         end
      end
   end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: two instances (period 16 x4, period 10 x2)
// compared every cycle against a period-position reference model.
module tb_pwm_multi;

   localparam int PER [2] = '{16, 10};
   localparam int CHN [2] = '{4, 2};
`ifdef PWM_MULTI_CENTER_EN
   localparam int MUL = 2;
`else
   localparam int MUL = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] in16 = '0;
   logic        v16 = 1'b0;
   logic        rdy16;
   logic [3:0]  out16;
   logic        sync16;
   logic [7:0]  in10 = '0;
   logic        v10 = 1'b0;
   logic        rdy10;
   logic [1:0]  out10;
   logic        sync10;

   int chk_cnt = 0;
   int err_cnt = 0;

   // reference model state: position within period, banks, expectations
   int       m_idx    [2];
   bit       m_pend   [2];
   int       m_shadow [2][4];
   int       m_active [2][4];
   bit [3:0] m_exp_out  [2];
   bit       m_exp_sync [2];
   int       hi_cnt [4];

   pwm_multi #(.period(16), .channels(4)) u_dut16 (
      .clk(clk), .rst(rst), .in(in16), .in_valid(v16),
      .in_ready(rdy16), .out(out16), .sync(sync16)
   );

   pwm_multi #(.period(10), .channels(2)) u_dut10 (
      .clk(clk), .rst(rst), .in(in10), .in_valid(v10),
      .in_ready(rdy10), .out(out10), .sync(sync10)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int len_of(input int d);
      return PER[d] * MUL;
   endfunction

   // counter value at a position in the period, straight from the count sequence
   function automatic int cnt_of(input int d, input int idx);
      if (MUL == 1) return idx;
      return (idx < PER[d]) ? idx : 2 * PER[d] - 1 - idx;
   endfunction

   function automatic int exp_hi(input int d, input int duty);
      return MUL * ((duty < PER[d]) ? duty : PER[d]);
   endfunction

   task automatic model_reset(input int d);
      m_idx[d]      = 0;
      m_pend[d]     = 1'b0;
      m_exp_out[d]  = '0;
      m_exp_sync[d] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         m_shadow[d][i] = 0;
         m_active[d][i] = 0;
      end
   endtask

   task automatic model_step(input int d, input bit valid, input logic [15:0] din);
      bit xfer;
      bit bnd;
      xfer = valid && !m_pend[d];
      bnd  = (m_idx[d] == len_of(d) - 1);
      for (int i = 0; i < CHN[d]; i++)
         m_exp_out[d][i] = (m_active[d][i] > cnt_of(d, m_idx[d]));
      m_exp_sync[d] = (m_idx[d] == 0);
      if (bnd) begin
         if (m_pend[d]) begin
            for (int i = 0; i < CHN[d]; i++) m_active[d][i] = m_shadow[d][i];
            m_pend[d] = 1'b0;
         end else if (xfer) begin
            for (int i = 0; i < CHN[d]; i++) m_active[d][i] = int'(din[i*4 +: 4]);
         end
      end else if (xfer) begin
         m_pend[d] = 1'b1;
      end
      if (xfer)
         for (int i = 0; i < CHN[d]; i++) m_shadow[d][i] = int'(din[i*4 +: 4]);
      m_idx[d] = (m_idx[d] + 1) % len_of(d);
   endtask

   // check current outputs, advance the model, then move to the next negedge
   task automatic cycle();
      check("out16",  32'(out16),  32'(m_exp_out[0]));
      check("sync16", 32'(sync16), 32'(m_exp_sync[0]));
      check("rdy16",  32'(rdy16),  32'(!m_pend[0]));
      check("out10",  32'(out10),  32'(m_exp_out[1][1:0]));
      check("sync10", 32'(sync10), 32'(m_exp_sync[1]));
      check("rdy10",  32'(rdy10),  32'(!m_pend[1]));
      model_step(0, v16, in16);
      model_step(1, v10, {8'h00, in10});
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_idx(input int d, input int target);
      int n;
      n = 0;
      while (m_idx[d] != target && n < 100) begin
         cycle();
         n++;
      end
      check("wait_idx", 32'(m_idx[d]), 32'(target));
   endtask

   task automatic add_sample(input int d);
      for (int k = 0; k < CHN[d]; k++)
         hi_cnt[k] += (d == 0) ? int'(out16[k]) : int'(out10[k]);
   endtask

   task automatic count_period(input int d);
      for (int k = 0; k < 4; k++) hi_cnt[k] = 0;
      for (int n = 0; n < len_of(d); n++) begin
         cycle();
         add_sample(d);
      end
   endtask

   task automatic check_counts(input string tag, input int d, input logic [15:0] din);
      for (int k = 0; k < CHN[d]; k++)
         check($sformatf("%s_ch%0d", tag, k), 32'(hi_cnt[k]), 32'(exp_hi(d, int'(din[k*4 +: 4]))));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out16"}, 32'(out16),  32'd0);
      check({tag, "_rdy16"}, 32'(rdy16),  32'd1);
      check({tag, "_syn16"}, 32'(sync16), 32'd0);
      check({tag, "_out10"}, 32'(out10),  32'd0);
      check({tag, "_rdy10"}, 32'(rdy10),  32'd1);
   endtask

   initial begin
      logic [15:0] duty_a;
      logic [15:0] duty_b;
      logic [15:0] duty_c;

      model_reset(0);
      model_reset(1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("por");
      rst = 1'b0;

      // random warm-up
      for (int n = 0; n < 40; n++) begin
         v16  = ($urandom_range(0, 2) == 0);
         in16 = 16'($urandom);
         v10  = ($urandom_range(0, 2) == 0);
         in10 = 8'($urandom);
         cycle();
      end
      v16 = 1'b0;
      v10 = 1'b0;

      // duty pattern 0/1/8/15
      wait_idx(0, 0);
      wait_idx(0, 3);
      duty_a = {4'd15, 4'd8, 4'd1, 4'd0};
      in16 = duty_a;
      v16  = 1'b1;
      cycle();
      v16 = 1'b0;
      wait_idx(0, 0);
      count_period(0);
      check_counts("duty", 0, duty_a);

      // handshake: first value held in shadow, valid kept high
      wait_idx(0, 3);
      duty_a = {4'd2, 4'd4, 4'd6, 4'd8};
      duty_b = {4'd12, 4'd10, 4'd3, 4'd5};
      in16 = duty_a;
      v16  = 1'b1;
      cycle();
      in16 = duty_b;
      for (int n = 0; n < 64 && m_idx[0] != 0; n++) begin
         check("hs_ready_low", 32'(rdy16), 32'd0);
         cycle();
      end
      check("hs_ready_high", 32'(rdy16), 32'd1);
      for (int k = 0; k < 4; k++) hi_cnt[k] = 0;
      cycle();
      add_sample(0);
      v16 = 1'b0;
      for (int n = 1; n < len_of(0); n++) begin
         cycle();
         add_sample(0);
      end
      check_counts("hs_first", 0, duty_a);
      count_period(0);
      check_counts("hs_second", 0, duty_b);

      // transfer on the boundary cycle goes straight to the next period
      wait_idx(0, len_of(0) - 1);
      duty_c = {4'd3, 4'd11, 4'd0, 4'd7};
      in16 = duty_c;
      v16  = 1'b1;
      cycle();
      v16 = 1'b0;
      check("bnd_ready", 32'(rdy16), 32'd1);
      count_period(0);
      check_counts("bnd", 0, duty_c);

      // saturation at period 10
      wait_idx(1, 2);
      in10 = {4'd10, 4'd12};
      v10  = 1'b1;
      cycle();
      v10 = 1'b0;
      wait_idx(1, 0);
      count_period(1);
      check_counts("sat_hi", 1, {8'h00, 4'd10, 4'd12});
      wait_idx(1, 2);
      in10 = {4'd0, 4'd9};
      v10  = 1'b1;
      cycle();
      v10 = 1'b0;
      wait_idx(1, 0);
      count_period(1);
      check_counts("sat_9", 1, {8'h00, 4'd0, 4'd9});

      // reset mid-period
      wait_idx(0, 7);
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_async");
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst_edge");
      rst = 1'b0;
      model_reset(0);
      model_reset(1);
      cycle();
      check("rst_first_sync", 32'(sync16), 32'd1);
      cycle();
      check("rst_sync_drop", 32'(sync16), 32'd0);

      // random soak
      for (int n = 0; n < 500; n++) begin
         v16  = ($urandom_range(0, 3) == 0);
         in16 = 16'($urandom);
         v10  = ($urandom_range(0, 3) == 0);
         in10 = 8'($urandom);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, err_cnt);
      $finish;
   end

endmodule
